// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package instr_fetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // One queued fetch result: the PC it was fetched from and the returned word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Debug stage, decoded from the credit/drop counters.
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t FQ_IDLE  = 2'd0;
    localparam fetch_state_t FQ_FILL  = 2'd1;
    localparam fetch_state_t FQ_DRAIN = 2'd2;
    localparam fetch_state_t FQ_FULL  = 2'd3;

    // Fetch addresses are word aligned; the low two bits of a target are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bundles the instruction-memory, redirect and decoder-side handshakes.
// master = the fetch queue, slave = memory/decoder/branch-unit environment.
interface instr_fetch_queue_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Circular buffer of fetch entries with flush; head reads as zero when empty.
module fetch_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next pointers and occupancy; flush wins over push and pop.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count_q gates the head so stale words never escape.
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential-PC fetch front end: issues word fetches under a credit limit,
// queues in-order responses, and flushes/drops stale responses on redirect.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_queue_if.master bus,
    output fetch_state_t        stage_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] count_w;
    logic [CW:0]   credit_used;
    logic          req_fire, dropping, push, pop;
    fetch_entry_t  push_entry, head;

    // Credits cover both queued entries and requests still in flight.
    assign credit_used        = {1'b0, count_w} + {1'b0, outstanding_q};
    assign bus.imem_req_valid = !rst && !bus.redirect_valid && (credit_used < DEPTH_W);
    assign bus.imem_req_addr  = fetch_pc_q;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    // A redirect discards the response of its own cycle and blocks the pop.
    assign dropping   = drop_cnt_q != '0;
    assign push       = bus.imem_resp_valid && !dropping && !bus.redirect_valid;
    assign pop        = bus.out_valid && bus.out_ready && !bus.redirect_valid;
    assign push_entry = '{pc: resp_pc_q, instr: bus.imem_resp_data};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (bus.redirect_valid),
        .head_o      (head),
        .count_o     (count_w)
    );

    assign bus.out_valid = count_w != '0;
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;

    // Next PCs and credit/drop accounting; redirect overrides normal flow.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (bus.redirect_valid) begin
            fetch_pc_d    = align_pc(bus.redirect_pc);
            resp_pc_d     = align_pc(bus.redirect_pc);
            // Everything still in flight belongs to the old stream; no request goes out this cycle.
            drop_cnt_d    = outstanding_q - {{(CW-1){1'b0}}, bus.imem_resp_valid};
            outstanding_d = drop_cnt_d;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (push)     resp_pc_d  = resp_pc_q + 32'd4;
            if (bus.imem_resp_valid && dropping) drop_cnt_d = drop_cnt_q - 1'b1;
            outstanding_d = outstanding_q + {{(CW-1){1'b0}}, req_fire}
                                          - {{(CW-1){1'b0}}, bus.imem_resp_valid};
        end
    end

    // PC, credit and drop registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Debug stage decode; draining stale responses takes precedence over fullness.
    always_comb begin
        stage_o = FQ_FILL;
        if (dropping)                                    stage_o = FQ_DRAIN;
        else if (credit_used == DEPTH_W)                 stage_o = FQ_FULL;
        else if (count_w == '0 && outstanding_q == '0)   stage_o = FQ_IDLE;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Front-end producer for the decode stage: generates sequential PCs and issues requests to instruction memory.
- Collects in-order responses into a small FIFO and presents {pc, instr} to the decoder through a valid/ready handshake.
- On redirect (branch/jump resolution, syscall, exception), it flushes the queue and discards in-flight responses.
- Sits between instruction memory and the decoder input.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2. Also bounds queue occupancy plus outstanding requests.
- RESET_PC, 32'h0000_3000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  response beat. Responses arrive in request order, ≥1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  redirect fetch stream.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decoder consumes head.
- out_pc  out  32  PC of head.
- out_instr  out  32  instruction word of head.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - On reset: fetch_pc=RESET_PC, resp_pc=RESET_PC, queue count=0, outstanding=0, drop_cnt=0.
  - Outputs after reset: imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0.
  - Reset mid-operation discards everything. Responses to pre-reset requests are not tracked; the memory model must be reset together with the block.
- Issue:
  - imem_req_valid = !rst && !redirect_valid && (count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - On req handshake: fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0) and outstanding += 1.
- Response:
  - Each imem_resp_valid decrements outstanding. The increment and decrement may occur in the same cycle and net to zero.
  - If drop_cnt>0: decrement drop_cnt and discard the data.
  - Otherwise: push {resp_pc, data} and set resp_pc += 4.
  - Overflow cannot occur by construction (the credit check above); the bench asserts it.
- Output:
  - out_valid = count != 0. out_pc and out_instr come from the head register (zero when empty).
  - Pop happens on out_valid && out_ready.
  - Push and pop in the same cycle (including when the queue is full) keep count unchanged.
  - A pop from an empty queue is impossible. When the queue is empty, the new entry appears on the cycle after push; there is no bypass, so resp-to-out latency is 1 cycle.
- Redirect (highest priority, effective in the same cycle):
  - Queue is cleared (count=0) and any pop this cycle is ignored.
  - fetch_pc and resp_pc are set to redirect_pc.
  - No request is issued this cycle.
  - drop_cnt <= outstanding − (imem_resp_valid ? 1 : 0). The response arriving this cycle is itself discarded.
  - outstanding <= drop_cnt_next; in-flight accounting is preserved.
  - First request for the new PC is issued at cycle N+1. The earliest out_valid is at N+1+L+1, where L is the memory latency.
- Back-to-back redirects: each redirect recomputes drop_cnt from the current outstanding; the last redirect wins.
- Counter widths: count, outstanding and drop_cnt are $clog2(DEPTH+1) bits.
- Invariants: count + outstanding ≤ DEPTH, and drop_cnt ≤ outstanding.
- Stage FSM, derived from the counters for debug:
  - IDLE: count=0, outstanding=0.
  - FILL: outstanding>0, drop_cnt=0.
  - DRAIN: drop_cnt>0.
  - FULL: count+outstanding=DEPTH.
  - Transitions follow the counters. DRAIN exits when drop_cnt reaches 0.

Decomposition:
- Shared header structs.svh gains:
  - RESET_PC_DEFAULT.
  - fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
  - fetch_state_t {FQ_IDLE, FQ_FILL, FQ_DRAIN, FQ_FULL}.
- Sub-module fetch_fifo (DEPTH, fetch_entry_t payload):
  - Ports: push, pop, flush, head, count.
  - Circular buffer with wrap-around read/write pointers.
- The top level holds the PC, credit and drop logic.

Test Plan:
- Reset release, memory latency 1, out_ready=1:
  - Requests go to 0x3000, 0x3004, 0x3008, … on consecutive cycles.
  - out_pc 0x3000 is first visible 2 cycles after the first request, then one entry per cycle with the matching data.
- out_ready=0 held with latency 1:
  - Exactly 4 requests are accepted, then imem_req_valid=0. count=4, outstanding=0.
  - One pop re-enables exactly one request.
- imem_req_ready=0 for 5 cycles:
  - imem_req_addr stays at 0x3000. No out_valid appears. fetch_pc is unchanged.
- Memory latency 3, redirect to 0x4000 with 2 requests outstanding and 1 entry queued:
  - out_valid drops the next cycle.
  - The 2 stale responses are discarded.
  - The first delivered entry has out_pc=0x4000.
- Redirect in the same cycle as imem_resp_valid and out_ready:
  - That response is dropped and the pop is ignored.
  - drop_cnt = outstanding−1.
  - No entry from the old stream ever appears on out_*.
- Redirect to 0xFFFF_FFF8 with out_ready=1:
  - Delivered PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Throughout all tests: assert rst mid-stream, then check that every output is at its reset value on the next cycle.
